tcu_drl_lane_collect: RTL

//  Return path of the TCU DRL lane mapping. Accepts per-lane results beat-by-beat (TCK physical lanes,

---
 rtl/tcu_drl_lane_collect.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tcu_drl_lane_collect.sv
// Return path of the TCU DRL lane mapping: gathers NUM_BEATS per-lane result beats into one
// wide writeback packet and rebuilds the input-slot valid mask (physical lane i -> slot i*4).
module tcu_drl_lane_collect #(
  parameter int          N              = 2,
  parameter int          TCK            = 2 * N,
  parameter int          DW             = 32,
  parameter int          NUM_BEATS      = 2,
  parameter int          TCU_MAX_INPUTS = 16,
  parameter logic [2:0]  TCU_FP32_ID    = 3'd0,
  parameter logic [2:0]  TCU_FP16_ID    = 3'd1,
  parameter logic [2:0]  TCU_BF16_ID    = 3'd2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_fmt,
  input  logic [TCK-1:0]                in_lane_mask,
  input  logic [TCK*DW-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    out_fmt,
  output logic [TCU_MAX_INPUTS-1:0]     out_vld_mask,
  output logic [NUM_BEATS*TCK*DW-1:0]   out_data,
  output logic                          out_err
);

  localparam int              CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int              BEAT_W    = TCK * DW;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NUM_BEATS - 1);

  if (NUM_BEATS < 1 || 4 * (TCK - 1) >= TCU_MAX_INPUTS) begin : g_cfg_check
    $error("tcu_drl_lane_collect: lane slots exceed TCU_MAX_INPUTS or NUM_BEATS < 1");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t                      state;
  logic [CW-1:0]               beat_cnt;
  logic [TCK-1:0]              eff_mask;
  logic                        beat_err;
  logic [TCU_MAX_INPUTS-1:0]   slot_mask;
  logic [BEAT_W-1:0]           beat_data;
  logic                        accept;
  logic                        dequeue;
  logic                        first_beat;

  // A held packet only blocks new beats when the consumer is not draining it this cycle.
  assign in_ready   = (state != FULL) || out_ready;
  assign out_valid  = (state == FULL);
  assign accept     = in_valid && in_ready && !flush;
  assign dequeue    = out_valid && out_ready && !flush;
  assign first_beat = (beat_cnt == '0);

  // NOTE: every output of this block gets a default up front so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    eff_mask  = '0;
    beat_err  = 1'b0;
    slot_mask = '0;
    beat_data = '0;
    case (in_fmt)
      TCU_FP32_ID: begin
        // FP32 occupies lane pairs; odd lanes carry nothing and a set odd bit is a producer error.
        for (int i = 0; i < TCK; i++) begin
          if (i % 2 == 1) begin
            if (in_lane_mask[i]) beat_err = 1'b1;
          end else begin
            eff_mask[i] = in_lane_mask[i];
          end
        end
      end
      TCU_FP16_ID, TCU_BF16_ID: eff_mask = in_lane_mask;
      default:                  beat_err = 1'b1;
    endcase
    for (int i = 0; i < TCK; i++) begin
      slot_mask[i*4]          = eff_mask[i];
      beat_data[i*DW +: DW]   = eff_mask[i] ? in_data[i*DW +: DW] : '0;
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      out_err      <= 1'b0;
      out_fmt      <= '0;
      out_vld_mask <= '0;
      // NOTE: the packet buffer is plain flops, so it is reset to give a defined zero output
      // before the first packet; a RAM-based buffer would not be reset.
      out_data     <= '0;
    end else if (flush) begin
      state    <= IDLE;
      beat_cnt <= '0;
      out_err  <= 1'b0;
    end else if (accept) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_cnt == CW'(b)) out_data[b*BEAT_W +: BEAT_W] <= beat_data;
      end
      if (first_beat) begin
        out_fmt      <= in_fmt;
        out_vld_mask <= slot_mask;
        out_err      <= beat_err;
      end else begin
        out_vld_mask <= out_vld_mask | slot_mask;
        out_err      <= out_err | beat_err | (in_fmt != out_fmt);
      end
      if (beat_cnt == LAST_BEAT) begin
        state    <= FULL;
        beat_cnt <= '0;
      end else begin
        state    <= COLLECT;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end else if (dequeue) begin
      state   <= IDLE;
      out_err <= 1'b0;
    end
  end

endmodule
